// File: rtl/kanagawa_fifo_ptrs_ex.sv
// Purpose : pointer/occupancy/flag controller for a circular FIFO with external RAM.
// Latency : all outputs registered; a request sampled at edge N is visible after edge N.
// Backpressure: pushes gated by full_out, pops gated by empty_out; gated requests are no-ops.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   wrreq_in          - push request; full_out / almost_full_out report fill level
//   wrptr_out         - RAM index the next push writes
//   usedw_out         - occupancy 0..DEPTH
//   rdreq_in          - pop request; empty_out / almost_empty_out report drain level
//   rdptr_out         - RAM index of the current head entry
// Optional: define KANAGAWA_FIFO_PTRS_CHECK_EN to compile simulation-only protocol checks.
module kanagawa_fifo_ptrs_ex #(
  parameter int DEPTH               = 27,
  parameter int ALMOST_FULL_MARGIN  = 5,
  parameter int ALMOST_EMPTY_MARGIN = 3,
  localparam int LOG_DEPTH          = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wrreq_in,
  output logic                 full_out,
  output logic                 almost_full_out,
  output logic [LOG_DEPTH-1:0] wrptr_out,
  output logic [LOG_DEPTH:0]   usedw_out,
  input  logic                 rdreq_in,
  output logic                 empty_out,
  output logic                 almost_empty_out,
  output logic [LOG_DEPTH-1:0] rdptr_out
);

  localparam logic [LOG_DEPTH-1:0] LAST_IDX = LOG_DEPTH'(DEPTH - 1);
  localparam logic [LOG_DEPTH:0]   DEPTH_W  = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   AF_THR   = (LOG_DEPTH+1)'(DEPTH - ALMOST_FULL_MARGIN);
  localparam logic [LOG_DEPTH:0]   AE_THR   = (LOG_DEPTH+1)'(ALMOST_EMPTY_MARGIN);

  logic                 we;
  logic                 re;
  logic [LOG_DEPTH-1:0] wrptr_nxt;
  logic [LOG_DEPTH-1:0] rdptr_nxt;
  logic [LOG_DEPTH:0]   usedw_nxt;

  always_comb begin
    we        = wrreq_in & ~full_out;
    re        = rdreq_in & ~empty_out;
    wrptr_nxt = wrptr_out;
    rdptr_nxt = rdptr_out;
    usedw_nxt = usedw_out;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths index the RAM correctly.
    if (we) wrptr_nxt = (wrptr_out == LAST_IDX) ? '0 : wrptr_out + LOG_DEPTH'(1);
    if (re) rdptr_nxt = (rdptr_out == LAST_IDX) ? '0 : rdptr_out + LOG_DEPTH'(1);

    unique case ({we, re})
      2'b10:   usedw_nxt = usedw_out + (LOG_DEPTH+1)'(1);
      2'b01:   usedw_nxt = usedw_out - (LOG_DEPTH+1)'(1);
      default: usedw_nxt = usedw_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr_out        <= '0;
      rdptr_out        <= '0;
      usedw_out        <= '0;
      // Full is held high in reset so no writer can push before the block is live.
      full_out         <= 1'b1;
      almost_full_out  <= 1'b1;
      empty_out        <= 1'b1;
      almost_empty_out <= 1'b1;
    end else begin
      wrptr_out        <= wrptr_nxt;
      rdptr_out        <= rdptr_nxt;
      usedw_out        <= usedw_nxt;
      // Flags derive from the next occupancy so they line up with usedw_out.
      full_out         <= (usedw_nxt == DEPTH_W);
      almost_full_out  <= (usedw_nxt > AF_THR);
      empty_out        <= (usedw_nxt == '0);
      almost_empty_out <= (usedw_nxt <= AE_THR);
    end
  end

`ifdef KANAGAWA_FIFO_PTRS_CHECK_EN
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(wrreq_in && full_out))
        else $error("kanagawa_fifo_ptrs_ex: push while full");
      assert (!(rdreq_in && empty_out))
        else $error("kanagawa_fifo_ptrs_ex: pop while empty");
      assert (usedw_out <= DEPTH_W)
        else $error("kanagawa_fifo_ptrs_ex: usedw above DEPTH");
    end
  end
`endif

endmodule

// File: tb/tb_kanagawa_fifo_ptrs_ex.sv
// Purpose : self-checking bench for kanagawa_fifo_ptrs_ex at default parameters (DEPTH=27).
// Latency : expects outputs one edge after each driven request.
// Backpressure: random traffic honours the model's full/empty; directed steps also drive gated requests.
module tb_kanagawa_fifo_ptrs_ex;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wrreq_in = 1'b0;
  logic       rdreq_in = 1'b0;
  logic       full_out, almost_full_out, empty_out, almost_empty_out;
  logic [4:0] wrptr_out, rdptr_out;
  logic [5:0] usedw_out;

  kanagawa_fifo_ptrs_ex dut (
    .clk              (clk),
    .rst              (rst),
    .wrreq_in         (wrreq_in),
    .full_out         (full_out),
    .almost_full_out  (almost_full_out),
    .wrptr_out        (wrptr_out),
    .usedw_out        (usedw_out),
    .rdreq_in         (rdreq_in),
    .empty_out        (empty_out),
    .almost_empty_out (almost_empty_out),
    .rdptr_out        (rdptr_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       full;
    logic       afull;
    logic       empty;
    logic       aempty;
    logic [5:0] usedw;
    logic [4:0] wp;
    logic [4:0] rp;
  } obs_t;

  typedef struct {
    logic r;
    logic wr;
    logic rd;
    obs_t exp;
  } vec_t;

  obs_t model;
  obs_t exp_q[$];
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  // Reference behaviour for DEPTH=27, afull threshold 22, aempty threshold 3.
  function automatic obs_t model_next(obs_t m, logic r, logic wr, logic rd);
    obs_t n;
    int   u;
    logic we, re;
    if (r) begin
      n = '{full:1'b1, afull:1'b1, empty:1'b1, aempty:1'b1, usedw:6'd0, wp:5'd0, rp:5'd0};
    end else begin
      we = wr & ~m.full;
      re = rd & ~m.empty;
      n  = m;
      if (we) n.wp = (m.wp == 5'd26) ? 5'd0 : m.wp + 5'd1;
      if (re) n.rp = (m.rp == 5'd26) ? 5'd0 : m.rp + 5'd1;
      u = int'(m.usedw) + (we ? 1 : 0) - (re ? 1 : 0);
      n.usedw  = 6'(u);
      n.full   = (u == 27);
      n.afull  = (u > 22);
      n.empty  = (u == 0);
      n.aempty = (u <= 3);
    end
    return n;
  endfunction

  task automatic compare(input string name);
    obs_t act, e;
    act = '{full:full_out, afull:almost_full_out, empty:empty_out, aempty:almost_empty_out,
            usedw:usedw_out, wp:wrptr_out, rp:rdptr_out};
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got full=%b af=%b empty=%b ae=%b usedw=%0d wp=%0d rp=%0d, want full=%b af=%b empty=%b ae=%b usedw=%0d wp=%0d rp=%0d",
               name, act.full, act.afull, act.empty, act.aempty, act.usedw, act.wp, act.rp,
               e.full, e.afull, e.empty, e.aempty, e.usedw, e.wp, e.rp);
    end
  endtask

  // Drive one cycle; the expected result is queued at drive time and checked after the edge.
  task automatic drive(input logic r, input logic wr, input logic rd,
                       input bit use_tbl, input obs_t texp, input string name);
    @(negedge clk);
    rst      = r;
    wrreq_in = wr;
    rdreq_in = rd;
    model    = model_next(model, r, wr, rd);
    exp_q.push_back(use_tbl ? texp : model);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit abort;
    abort = 0;
    model = '0;

    // r wr rd : full af empty ae usedw wp rp
    vecs[0]  = '{1'b1, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 5'd0, 5'd0}};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, '{1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 5'd0, 5'd0}};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 5'd0, 5'd0}};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 5'd0, 5'd0}};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd1, 5'd0}};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd2, 5'd1}};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 5'd2, 5'd2}};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, '{1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd3, 5'd2}};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 5'd4, 5'd2}};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 5'd4, 5'd2}};
    vecs[10] = '{1'b0, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 5'd5, 5'd2}};
    vecs[11] = '{1'b0, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 6'd4, 5'd6, 5'd2}};
    vecs[12] = '{1'b1, 1'b1, 1'b0, '{1'b1, 1'b1, 1'b1, 1'b1, 6'd0, 5'd0, 5'd0}};
    vecs[13] = '{1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 5'd0, 5'd0}};

    for (int i = 0; i < 14; i++)
      drive(vecs[i].r, vecs[i].wr, vecs[i].rd, 1'b1, vecs[i].exp, $sformatf("vec%0d", i));

    // Fill from empty: flag transitions and write-pointer wrap.
    for (int i = 1; i <= 27; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, $sformatf("fill%0d", i));
      if (i == 1)  chk("empty_after_push1", int'(empty_out), 0);
      if (i == 3)  chk("aempty_after_push3", int'(almost_empty_out), 1);
      if (i == 4)  chk("aempty_after_push4", int'(almost_empty_out), 0);
      if (i == 22) chk("afull_after_push22", int'(almost_full_out), 0);
      if (i == 23) chk("afull_after_push23", int'(almost_full_out), 1);
      if (i == 26) chk("full_after_push26", int'(full_out), 0);
      if (i == 27) begin
        chk("full_after_push27", int'(full_out), 1);
        chk("wrptr_wrap", int'(wrptr_out), 0);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, "push_while_full");
    chk("usedw_push_full", int'(usedw_out), 27);

    // Drain from full: flag transitions and read-pointer wrap.
    for (int i = 1; i <= 27; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0, $sformatf("drain%0d", i));
      if (i == 1)  chk("full_after_pop1", int'(full_out), 0);
      if (i == 4)  chk("afull_usedw23", int'(almost_full_out), 1);
      if (i == 5)  chk("afull_usedw22", int'(almost_full_out), 0);
      if (i == 23) chk("aempty_usedw4", int'(almost_empty_out), 0);
      if (i == 24) chk("aempty_usedw3", int'(almost_empty_out), 1);
      if (i == 27) begin
        chk("empty_after_drain", int'(empty_out), 1);
        chk("rdptr_wrap", int'(rdptr_out), 0);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, "pop_while_empty");
    chk("rdptr_pop_empty", int'(rdptr_out), 0);

    // Simultaneous push/pop at usedw=10.
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, "to10");
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, "pushpop10");
    chk("usedw_pushpop", int'(usedw_out), 10);
    chk("wrptr_pushpop", int'(wrptr_out), 11);
    chk("rdptr_pushpop", int'(rdptr_out), 1);

    // Push+pop while full: only the pop takes effect.
    for (int i = 0; i < 17; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, "refill");
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, "pushpop_full");
    chk("usedw_pushpop_full", int'(usedw_out), 26);
    chk("wrptr_pushpop_full", int'(wrptr_out), 1);

    // Reset mid-operation discards occupancy.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, "mid_reset");
    chk("usedw_mid_reset", int'(usedw_out), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, "mid_release");

    // Random traffic: writer and reader with independent 1-10 cycle stalls.
    for (int it = 0; it < 100 && !abort; it++) begin
      int   wl, rl, ws, rs, idle;
      logic w, r;
      wl = 27; rl = 27; idle = 0;
      ws = $urandom_range(1, 10);
      rs = $urandom_range(1, 10);
      while (rl > 0 && !abort) begin
        w = (wl > 0) && (ws == 0) && !model.full;
        r = (rs == 0) && !model.empty;
        drive(1'b0, w, r, 1'b0, '0, "random");
        if (ws > 0) ws--;
        else if (w) begin
          wl--;
          ws = $urandom_range(1, 10);
        end
        if (rs > 0) rs--;
        else if (r) begin
          rl--;
          rs = $urandom_range(1, 10);
        end
        if (r) idle = 0;
        else idle++;
        if (idle > 1000) begin
          errors++;
          $display("FAIL read_timeout: iteration %0d, %0d reads outstanding", it, rl);
          abort = 1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
